// File: rtl/cfg_pkg.sv
// Shared configuration constants and types for the Si5340 bring-up path.
// Holds the I2C address, page-select offset, and the register-writer step and state types.
package cfg_pkg;

    localparam logic [6:0] SLAVE_ADDR = 7'h74;
    localparam logic [7:0] PAGE_REG   = 8'h01;
    localparam int         STEP_DEPTH = 7;

    typedef enum logic {
        WRITE = 1'b0,
        READ  = 1'b1
    } r_w_e;

    typedef struct packed {
        logic [7:0] data;
        r_w_e       rw;
        logic       start;
        logic       stop;
        logic       ack_in;
    } step_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PLAN,
        ST_CMD,
        ST_GAP,
        ST_ABORT,
        ST_DONE
    } writer_state_e;

    function automatic step_t mk_step(input logic [7:0] data, input r_w_e rw,
                                      input logic start, input logic stop,
                                      input logic ack_in);
        step_t s;
        s.data   = data;
        s.rw     = rw;
        s.start  = start;
        s.stop   = stop;
        s.ack_in = ack_in;
        return s;
    endfunction

endpackage

// File: rtl/si5340_reg_writer.sv
// Expands one 16-bit paged register access into i2c_master_byte commands,
// skipping the page-select write when the cached page already matches.
module si5340_reg_writer
    import cfg_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = cfg_pkg::SLAVE_ADDR,
    parameter logic [7:0] PAGE_REG   = cfg_pkg::PAGE_REG,
    parameter int         DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  arstn_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [15:0]           s_addr_i,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_rw_i,
    input  logic                  page_flush_i,
    output logic                  done_o,
    output logic                  err_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  start_o,
    output logic                  stop_o,
    output logic                  read_o,
    output logic                  write_o,
    output logic                  ack_in_o,
    output logic [DATA_WIDTH-1:0] din_o,
    input  logic [DATA_WIDTH-1:0] dout_i,
    input  logic                  cmd_ack_i,
    input  logic                  ack_out_i
);

    localparam logic [7:0] SLA_W = {SLAVE_ADDR, 1'b0};
    localparam logic [7:0] SLA_R = {SLAVE_ADDR, 1'b1};

    writer_state_e         state_q, state_d;
    step_t                 steps_q [STEP_DEPTH];
    step_t                 steps_d [STEP_DEPTH];
    step_t                 plan_steps [STEP_DEPTH];
    logic [2:0]            idx_q, idx_d, last_q, last_d, plan_last, plan_base;
    logic                  page_phase_q, page_phase_d, plan_page;
    logic [15:0]           addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    r_w_e                  rw_q, rw_d;
    logic [7:0]            page_q, page_d;
    logic                  page_valid_q, page_valid_d;
    logic                  err_q, err_d;
    logic                  start_q, start_d, stop_q, stop_d, read_q, read_d;
    logic                  write_q, write_d, ack_in_q, ack_in_d;
    logic [DATA_WIDTH-1:0] din_q, din_d, rd_data_q, rd_data_d;
    logic                  done_q, done_d, err_o_q, err_o_d;
    step_t                 cur_step, nxt_step;

    // Step list for the latched access; consumed only in PLAN.
    always_comb begin
        for (int i = 0; i < STEP_DEPTH; i++) begin
            plan_steps[i] = '0;
        end
        plan_page = !page_valid_q || (page_q != addr_q[15:8]);
        plan_base = plan_page ? 3'd3 : 3'd0;
        if (plan_page) begin
            plan_steps[0] = mk_step(SLA_W, WRITE, 1'b1, 1'b0, 1'b0);
            plan_steps[1] = mk_step(PAGE_REG, WRITE, 1'b0, 1'b0, 1'b0);
            plan_steps[2] = mk_step(addr_q[15:8], WRITE, 1'b0, 1'b1, 1'b0);
        end
        plan_steps[plan_base]        = mk_step(SLA_W, WRITE, 1'b1, 1'b0, 1'b0);
        plan_steps[plan_base + 3'd1] = mk_step(addr_q[7:0], WRITE, 1'b0, 1'b0, 1'b0);
        if (rw_q == READ) begin
            plan_steps[plan_base + 3'd2] = mk_step(SLA_R, WRITE, 1'b1, 1'b0, 1'b0);
            plan_steps[plan_base + 3'd3] = mk_step(8'h00, READ, 1'b0, 1'b1, 1'b1);
            plan_last = plan_base + 3'd3;
        end else begin
            plan_steps[plan_base + 3'd2] = mk_step(data_q, WRITE, 1'b0, 1'b1, 1'b0);
            plan_last = plan_base + 3'd2;
        end
    end

    assign cur_step = steps_q[idx_q];
    assign nxt_step = steps_q[idx_q + 3'd1];

    always_comb begin
        state_d      = state_q;
        steps_d      = steps_q;
        idx_d        = idx_q;
        last_d       = last_q;
        page_phase_d = page_phase_q;
        addr_d       = addr_q;
        data_d       = data_q;
        rw_d         = rw_q;
        page_d       = page_q;
        page_valid_d = page_valid_q;
        err_d        = err_q;
        start_d      = start_q;
        stop_d       = stop_q;
        read_d       = read_q;
        write_d      = write_q;
        ack_in_d     = ack_in_q;
        din_d        = din_q;
        rd_data_d    = rd_data_q;
        done_d       = 1'b0;
        err_o_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (s_valid_i) begin
                    addr_d  = s_addr_i;
                    data_d  = s_data_i;
                    rw_d    = s_rw_i ? READ : WRITE;
                    err_d   = 1'b0;
                    state_d = ST_PLAN;
                end
            end
            ST_PLAN: begin
                steps_d      = plan_steps;
                last_d       = plan_last;
                idx_d        = 3'd0;
                page_phase_d = plan_page;
                start_d      = plan_steps[0].start;
                stop_d       = plan_steps[0].stop;
                read_d       = (plan_steps[0].rw == READ);
                write_d      = (plan_steps[0].rw == WRITE);
                ack_in_d     = plan_steps[0].ack_in;
                din_d        = plan_steps[0].data;
                state_d      = ST_CMD;
            end
            ST_CMD: begin
                if (cmd_ack_i) begin
                    // Drop everything for at least one cycle so the controller cannot retrigger.
                    start_d  = 1'b0;
                    stop_d   = 1'b0;
                    read_d   = 1'b0;
                    write_d  = 1'b0;
                    ack_in_d = 1'b0;
                    din_d    = '0;
                    if (cur_step.rw == READ) begin
                        rd_data_d = dout_i;
                    end
                    if ((cur_step.rw == WRITE) && ack_out_i) begin
                        err_d        = 1'b1;
                        page_valid_d = 1'b0;
                        state_d      = ST_ABORT;
                    end else begin
                        if (page_phase_q && (idx_q == 3'd2)) begin
                            page_d       = addr_q[15:8];
                            page_valid_d = 1'b1;
                        end
                        if (idx_q == last_q) begin
                            done_d  = 1'b1;
                            err_o_d = err_q;
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_GAP;
                        end
                    end
                end
            end
            ST_GAP: begin
                idx_d    = idx_q + 3'd1;
                start_d  = nxt_step.start;
                stop_d   = nxt_step.stop;
                read_d   = (nxt_step.rw == READ);
                write_d  = (nxt_step.rw == WRITE);
                ack_in_d = nxt_step.ack_in;
                din_d    = nxt_step.data;
                state_d  = ST_CMD;
            end
            ST_ABORT: begin
                // First ABORT cycle stays quiet, then a lone stop releases the bus.
                if (!stop_q) begin
                    stop_d = 1'b1;
                end else if (cmd_ack_i) begin
                    stop_d  = 1'b0;
                    done_d  = 1'b1;
                    err_o_d = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (page_flush_i) begin
            page_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q      <= ST_IDLE;
            for (int i = 0; i < STEP_DEPTH; i++) begin
                steps_q[i] <= '0;
            end
            idx_q        <= '0;
            last_q       <= '0;
            page_phase_q <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            rw_q         <= WRITE;
            page_q       <= '0;
            page_valid_q <= 1'b0;
            err_q        <= 1'b0;
            start_q      <= 1'b0;
            stop_q       <= 1'b0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            ack_in_q     <= 1'b0;
            din_q        <= '0;
            rd_data_q    <= '0;
            done_q       <= 1'b0;
            err_o_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            steps_q      <= steps_d;
            idx_q        <= idx_d;
            last_q       <= last_d;
            page_phase_q <= page_phase_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            rw_q         <= rw_d;
            page_q       <= page_d;
            page_valid_q <= page_valid_d;
            err_q        <= err_d;
            start_q      <= start_d;
            stop_q       <= stop_d;
            read_q       <= read_d;
            write_q      <= write_d;
            ack_in_q     <= ack_in_d;
            din_q        <= din_d;
            rd_data_q    <= rd_data_d;
            done_q       <= done_d;
            err_o_q      <= err_o_d;
        end
    end

    // Ready is held low while reset is asserted and rises as soon as it releases.
    assign s_ready_o = arstn_i && (state_q == ST_IDLE);
    assign done_o    = done_q;
    assign err_o     = err_o_q;
    assign rd_data_o = rd_data_q;
    assign start_o   = start_q;
    assign stop_o    = stop_q;
    assign read_o    = read_q;
    assign write_o   = write_q;
    assign ack_in_o  = ack_in_q;
    assign din_o     = din_q;

endmodule

// File: tb/tb_si5340_reg_writer.sv
// Scoreboard bench for si5340_reg_writer: a byte-controller model acknowledges
// commands while a monitor compares each new command and each done pulse.
module tb_si5340_reg_writer;

    logic        clk_i = 1'b0;
    logic        arstn_i;
    logic        s_valid_i;
    logic        s_ready_o;
    logic [15:0] s_addr_i;
    logic [7:0]  s_data_i;
    logic        s_rw_i;
    logic        page_flush_i;
    logic        done_o;
    logic        err_o;
    logic [7:0]  rd_data_o;
    logic        start_o, stop_o, read_o, write_o, ack_in_o;
    logic [7:0]  din_o;
    logic [7:0]  dout_i;
    logic        cmd_ack_i;
    logic        ack_out_i;

    always #5 clk_i = ~clk_i;

    si5340_reg_writer dut (
        .clk_i       (clk_i),
        .arstn_i     (arstn_i),
        .s_valid_i   (s_valid_i),
        .s_ready_o   (s_ready_o),
        .s_addr_i    (s_addr_i),
        .s_data_i    (s_data_i),
        .s_rw_i      (s_rw_i),
        .page_flush_i(page_flush_i),
        .done_o      (done_o),
        .err_o       (err_o),
        .rd_data_o   (rd_data_o),
        .start_o     (start_o),
        .stop_o      (stop_o),
        .read_o      (read_o),
        .write_o     (write_o),
        .ack_in_o    (ack_in_o),
        .din_o       (din_o),
        .dout_i      (dout_i),
        .cmd_ack_i   (cmd_ack_i),
        .ack_out_i   (ack_out_i)
    );

    int          checks = 0;
    int          errors = 0;
    logic [12:0] exp_cmd_q [$];
    logic [8:0]  exp_done_q [$];
    bit          nack_next = 1'b0;
    logic [7:0]  slave_rd = 8'h00;
    logic [7:0]  exp_rd = 8'h00;
    logic        any_cmd;

    // model state
    int          m_cnt = 0;
    bit          m_busy = 1'b0;
    bit          m_nack = 1'b0;
    // monitor state
    bit          prev_any = 1'b0;
    logic [12:0] got_cmd;
    logic [8:0]  exp_d;

    assign any_cmd = start_o | stop_o | read_o | write_o | ack_in_o;

    function automatic logic [12:0] mk(input bit st, input bit sp, input bit rd,
                                       input bit wr, input bit ai, input logic [7:0] d);
        return {st, sp, rd, wr, ai, d};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_page(input logic [7:0] p);
        exp_cmd_q.push_back(mk(1, 0, 0, 1, 0, 8'hE8));
        exp_cmd_q.push_back(mk(0, 0, 0, 1, 0, 8'h01));
        exp_cmd_q.push_back(mk(0, 1, 0, 1, 0, p));
    endtask

    // Byte-controller model: acknowledges each command a few cycles after it appears.
    initial begin
        cmd_ack_i = 1'b0;
        ack_out_i = 1'b0;
        dout_i    = 8'h00;
        forever begin
            @(negedge clk_i);
            if (!arstn_i) begin
                m_busy    = 1'b0;
                cmd_ack_i = 1'b0;
                ack_out_i = 1'b0;
            end else if (cmd_ack_i) begin
                cmd_ack_i = 1'b0;
                ack_out_i = 1'b0;
            end else if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    cmd_ack_i = 1'b1;
                    ack_out_i = m_nack;
                    dout_i    = slave_rd;
                    m_busy    = 1'b0;
                end
            end else if (any_cmd) begin
                m_busy = 1'b1;
                m_cnt  = 2;
                m_nack = nack_next && write_o;
                if (m_nack) nack_next = 1'b0;
            end
        end
    end

    // Monitor: compares each newly asserted command and each done pulse.
    initial begin
        forever begin
            @(negedge clk_i);
            if (!arstn_i) begin
                prev_any = 1'b0;
            end else begin
                if (any_cmd && !prev_any) begin
                    got_cmd = {start_o, stop_o, read_o, write_o, ack_in_o, din_o};
                    if (exp_cmd_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_cmd: got %0h expected none", got_cmd);
                    end else begin
                        check("cmd", 32'(got_cmd), 32'(exp_cmd_q.pop_front()));
                    end
                end
                prev_any = any_cmd;
                if (done_o) begin
                    if (exp_done_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got err %0b expected none", err_o);
                    end else begin
                        exp_d = exp_done_q.pop_front();
                        check("done_err", 32'(err_o), 32'(exp_d[8]));
                        check("done_rd_data", 32'(rd_data_o), 32'(exp_d[7:0]));
                    end
                end
            end
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 50 && !s_ready_o; i++) @(negedge clk_i);
        check("ready_wait", 32'(s_ready_o), 32'd1);
    endtask

    task automatic access(input logic [15:0] a, input logic [7:0] d, input bit rd,
                          input bit pg, input bit nack, input logic [7:0] slv, input bit hold);
        if (nack) begin
            if (pg) exp_cmd_q.push_back(mk(1, 0, 0, 1, 0, 8'hE8));
            else    exp_cmd_q.push_back(mk(1, 0, 0, 1, 0, 8'hE8));
            exp_cmd_q.push_back(mk(0, 1, 0, 0, 0, 8'h00));
            exp_done_q.push_back({1'b1, exp_rd});
        end else begin
            if (pg) push_page(a[15:8]);
            exp_cmd_q.push_back(mk(1, 0, 0, 1, 0, 8'hE8));
            exp_cmd_q.push_back(mk(0, 0, 0, 1, 0, a[7:0]));
            if (rd) begin
                exp_cmd_q.push_back(mk(1, 0, 0, 1, 0, 8'hE9));
                exp_cmd_q.push_back(mk(0, 1, 1, 0, 1, 8'h00));
                exp_rd = slv;
            end else begin
                exp_cmd_q.push_back(mk(0, 1, 0, 1, 0, d));
            end
            exp_done_q.push_back({1'b0, exp_rd});
        end
        slave_rd  = slv;
        nack_next = nack;
        wait_ready();
        s_valid_i = 1'b1;
        s_addr_i  = a;
        s_data_i  = d;
        s_rw_i    = rd;
        @(posedge clk_i);
        #1;
        if (!hold) s_valid_i = 1'b0;
        check("plan_no_cmd", 32'(any_cmd), 32'd0);
        @(posedge clk_i);
        #1;
        check("first_cmd_latency", 32'(any_cmd), 32'd1);
        if (hold) begin
            // A request arriving mid-transaction must be ignored.
            s_addr_i = 16'hFFFF;
            s_data_i = 8'hFF;
            repeat (3) @(posedge clk_i);
            #1;
            s_valid_i = 1'b0;
        end
        for (int i = 0; i < 400 && !done_o; i++) @(negedge clk_i);
        check("done_seen", 32'(done_o), 32'd1);
        @(negedge clk_i);
        check("ready_after_done", 32'(s_ready_o), 32'd1);
    endtask

    initial begin
        arstn_i      = 1'b0;
        s_valid_i    = 1'b0;
        s_addr_i     = 16'h0000;
        s_data_i     = 8'h00;
        s_rw_i       = 1'b0;
        page_flush_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rst_ready", 32'(s_ready_o), 32'd0);
        check("rst_cmds", 32'(any_cmd), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_rd_data", 32'(rd_data_o), 32'd0);
        check("rst_din", 32'(din_o), 32'd0);
        arstn_i = 1'b1;
        #1;
        check("ready_after_release", 32'(s_ready_o), 32'd1);

        access(16'h0B24, 8'hC0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        access(16'h0B25, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        access(16'h0B0E, 8'h00, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b0);
        access(16'h0B30, 8'h11, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        access(16'h0B31, 8'h22, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        @(negedge clk_i);
        page_flush_i = 1'b1;
        @(negedge clk_i);
        page_flush_i = 1'b0;
        access(16'h0B32, 8'h33, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        access(16'h0B33, 8'h44, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        access(16'h0D01, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0);
        access(16'h0D02, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        // Reset in the middle of a command.
        exp_cmd_q.push_back(mk(1, 0, 0, 1, 0, 8'hE8));
        wait_ready();
        s_valid_i = 1'b1;
        s_addr_i  = 16'h0D11;
        s_data_i  = 8'h66;
        s_rw_i    = 1'b0;
        @(posedge clk_i);
        #1;
        s_valid_i = 1'b0;
        for (int i = 0; i < 20 && !any_cmd; i++) @(negedge clk_i);
        check("midrst_cmd_seen", 32'(any_cmd), 32'd1);
        #2;
        arstn_i = 1'b0;
        #1;
        check("midrst_cmds", 32'(any_cmd), 32'd0);
        check("midrst_ready", 32'(s_ready_o), 32'd0);
        check("midrst_done", 32'(done_o), 32'd0);
        exp_cmd_q.delete();
        exp_done_q.delete();
        exp_rd = 8'h00;
        repeat (2) @(negedge clk_i);
        arstn_i = 1'b1;
        #1;
        check("midrst_ready_release", 32'(s_ready_o), 32'd1);
        access(16'h0D12, 8'h77, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

        repeat (5) @(negedge clk_i);
        check("cmd_queue_empty", 32'(exp_cmd_q.size()), 32'd0);
        check("done_queue_empty", 32'(exp_done_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/si5340_reg_writer.md
# si5340_reg_writer

Transaction engine between the Si5340 configuration sequencing logic and the I2C byte controller (`i2c_master_byte`). Accepts one 16-bit register access per valid/ready handshake and expands it into the byte-command sequence the Si5340 paged register map requires. Inserts a page-register write only when the target page differs from the cached page. Reports completion, NACK errors and read data.

## Interface
Parameters:
- SLAVE_ADDR, 7'h74, Si5340 7-bit I2C address
- PAGE_REG, 8'h01, page-select register offset
- DATA_WIDTH, 8, I2C byte width

Ports:
- clk_i  in  1  clock
- arstn_i  in  1  reset, asynchronous, active-low
- s_valid_i  in  1  access request
- s_ready_o  out  1  engine idle; request accepted on s_valid_i & s_ready_o
- s_addr_i  in  16  [15:8] page, [7:0] register offset
- s_data_i  in  8  write data
- s_rw_i  in  1  1 = read, 0 = write
- page_flush_i  in  1  invalidate page cache
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  NACK seen in this access; valid only with done_o
- rd_data_o  out  8  read result; held until next read completes
- start_o, stop_o, read_o, write_o, ack_in_o  out  1 each  byte-controller commands
- din_o  out  8  byte to transmit
- dout_i  in  8  received byte
- cmd_ack_i  in  1  byte command complete
- ack_out_i  in  1  slave acknowledge bit: 0 = ACK, 1 = NACK

## Operation
- States: IDLE, PLAN, CMD, GAP, ABORT, DONE.
- IDLE: s_ready_o=1. On handshake, latch addr/data/rw and go to PLAN.
- PLAN (1 cycle): build a step list, step index = 0.
  - Page phase, only if !page_valid or page_q != addr[15:8]:
    - {SLA+W, start}
    - {PAGE_REG}
    - {page, stop}
  - Write phase:
    - {SLA+W, start}
    - {offset}
    - {data, stop}
  - Read phase:
    - {SLA+W, start}
    - {offset}
    - {SLA+R, start}
    - {read, ack_in=1, stop}
- CMD: drive the current step's command bits and din_o; hold them constant until cmd_ack_i.
  - On cmd_ack_i of a write step with ack_out_i=1: go to ABORT.
  - On cmd_ack_i of the last step: go to DONE.
  - On any other cmd_ack_i: go to GAP.
  - On cmd_ack_i of the read step: rd_data_o <= dout_i.
- GAP: all commands 0 for one cycle, increment step index, return to CMD.
- ABORT: issue stop_o alone until cmd_ack_i, set err flag, clear page_valid, then go to DONE.
- DONE: done_o=1 and err_o=err flag for one cycle, then IDLE.
- Page cache: page_q/page_valid updated on ACK of the page-phase third step.
  - page_flush_i clears page_valid in any state.
  - If a flush coincides with a page update, the flush wins.
- Read-only and write accesses share the cache.

## Timing
- Reset values:
  - s_ready_o: 0 during reset, 1 in the first cycle after release
  - all commands, done_o, err_o, rd_data_o, din_o: 0
  - page_valid: 0
- Handshake to first command assertion: 2 cycles (PLAN, then CMD).
- Commands drop the cycle after cmd_ack_i, so at least one low cycle separates byte commands and the controller never retriggers.
- done_o fires 1 cycle after the final cmd_ack_i. s_ready_o rises the cycle after done_o.
- s_valid_i is ignored outside IDLE. Inputs need not be held after the handshake.
- Reset mid-transaction: async return to IDLE, all commands 0, cache invalidated. The byte controller shares arstn_i, so the bus is released.
- cmd_ack_i outside CMD/ABORT is ignored.

## Structure
- cfg_pkg gains:
  - PAGE_REG
  - r_w enum (WRITE=0, READ=1)
  - step struct {data, rw, start, stop, ack_in}
  - writer state enum
- SLAVE_ADDR reuses the existing cfg_pkg constant.
- Single module; the step list is a 7-entry array indexed by a 3-bit counter. No sub-module.
- i2c_master_byte is instantiated by the parent, not here.

## Test plan
- Write 0x0B24=0xC0 from reset: expect bytes E8(start), 01, 0B(stop), E8(start), 24, C0(stop). done_o with err_o=0. s_ready_o returns high.
- Then write 0x0B25=0x00: no page phase; exactly 3 byte commands E8, 25, 00(stop).
- Read 0x0B0E, slave returns 0x5A: commands E8(start), 0E, E9(start), read+ack_in+stop. rd_data_o=0x5A at done_o.
- NACK on the SLA+W byte: ABORT issues a stop-only command, done_o with err_o=1. The next access to page 0x0B repeats the page phase.
- Assert page_flush_i between two page-0x0B writes: the second write includes the page phase.
- Assert arstn_i low mid-CMD: all commands 0 immediately. After release, s_ready_o=1 and the next write includes the page phase.
